// File: rtl/sapho_io_hub_pkg.sv
// Shared constants and helper functions for the SAPHO I/O hub.
package sapho_io_pkg;

  // Bit positions inside err_flags.
  localparam int ERR_UNDER = 0;
  localparam int ERR_OVER  = 1;
  localparam int ERR_SEL   = 2;

  // Ceiling log2 for elaboration-time sizing (clog2(1) = 0).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((1 << i) < v) ? (i + 1) : r;
    end
    return r;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic onehot_ok(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/sapho_io_hub_if.sv
// Datapath/core-side bundle of the SAPHO I/O hub. The hub uses the slave
// modport; whatever drives the hub (core + datapath, or a bench) uses master.
interface sapho_io_hub_if #(
  parameter int DW    = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 5
);
  logic [N_IN*DW-1:0]  in_data;
  logic [N_IN-1:0]     in_valid;
  logic [N_IN-1:0]     in_ready;
  logic [N_IN-1:0]     req_in;
  logic [DW-1:0]       proc_in;
  logic [DW-1:0]       proc_out;
  logic [N_OUT-1:0]    out_en;
  logic [N_OUT*DW-1:0] out_data;
  logic [N_OUT-1:0]    out_valid;
  logic [N_OUT-1:0]    out_ready;
  logic                itr;
  logic [2:0]          err_flags;

  modport slave (
    input  in_data, in_valid, req_in, proc_out, out_en, out_ready,
    output in_ready, proc_in, out_data, out_valid, itr, err_flags
  );

  modport master (
    output in_data, in_valid, req_in, proc_out, out_en, out_ready,
    input  in_ready, proc_in, out_data, out_valid, itr, err_flags
  );
endinterface

// File: rtl/io_fifo.sv
// Output-channel FIFO. The head is kept in a register so out_valid/out_data
// appear one cycle after a push (no fall-through) and the head holds the last
// popped value while empty.
module io_fifo
  import sapho_io_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_geral,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full
);
  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] head;
  logic          do_pop;
  logic          do_push;
  logic [AW-1:0] rd_ptr_n;
  logic [AW:0]   count_n;

  // Accepted push/pop and the pointer/count they lead to.
  always_comb begin
    do_pop   = pop & (count != '0);
    do_push  = push & ((count != FULL_CNT) | do_pop);
    rd_ptr_n = do_pop ? (rd_ptr + AW'(1)) : rd_ptr;
    count_n  = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  end

  // Storage, pointers and the registered head value.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // A push into the slot that becomes the head bypasses the memory.
      if (count_n != '0) begin
        head <= (do_push && (wr_ptr == rd_ptr_n)) ? din : mem[rd_ptr_n];
      end else begin
        head <= head;
      end
    end
  end

  assign dout  = head;
  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
endmodule

// File: rtl/sapho_io_hub.sv
// I/O hub between a SAPHO core and its datapath: 1-deep input holding
// registers read through a one-hot select, per-channel output FIFOs written
// by broadcast enables, an arrival interrupt and sticky diagnostic flags.
module sapho_io_hub
  import sapho_io_pkg::*;
#(
  parameter int              DW        = 32,
  parameter int              N_IN      = 2,
  parameter int              N_OUT     = 5,
  parameter int              OUT_DEPTH = 4,
  parameter logic [N_IN-1:0] ITR_MASK  = '1
) (
  input logic             clk,
  input logic             rst_geral,
  sapho_io_hub_if.slave   io
);
  logic [DW-1:0]    hold [N_IN];
  logic [N_IN-1:0]  hv;
  logic [N_IN-1:0]  pop;
  logic [N_IN-1:0]  cap;
  logic [N_IN-1:0]  in_rdy;
  logic             sel_ok;
  logic [DW-1:0]    rd_mux;
  logic [DW-1:0]    f_dout [N_OUT];
  logic [N_OUT-1:0] f_valid;
  logic [N_OUT-1:0] f_full;
  logic [N_OUT-1:0] f_over;
  logic             itr_r;
  logic [2:0]       err_r;

  // Read select decode, pops, captures and the read mux.
  always_comb begin
    sel_ok = onehot_ok(32'(io.req_in));
    pop    = sel_ok ? (io.req_in & hv) : '0;
    in_rdy = ~hv | pop;
    cap    = io.in_valid & in_rdy;
    rd_mux = '0;
    for (int k = 0; k < N_IN; k++) begin
      rd_mux = (sel_ok && io.req_in[k]) ? hold[k] : rd_mux;
    end
  end

  // Input holding registers; a same-cycle capture overrides the pop.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      hv <= '0;
      for (int k = 0; k < N_IN; k++) hold[k] <= '0;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (cap[k]) begin
          hold[k] <= io.in_data[k*DW +: DW];
          hv[k]   <= 1'b1;
        end else if (pop[k]) begin
          hv[k] <= 1'b0;
        end else begin
          hv[k] <= hv[k];
        end
      end
    end
  end

  // Interrupt pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst_geral) begin
      itr_r <= 1'b0;
      err_r <= 3'b000;
    end else begin
      itr_r            <= |(cap & ITR_MASK);
      err_r[ERR_UNDER] <= err_r[ERR_UNDER] | (sel_ok & (|(io.req_in & ~hv)));
      err_r[ERR_OVER]  <= err_r[ERR_OVER] | (|f_over);
      err_r[ERR_SEL]   <= err_r[ERR_SEL] | ((io.req_in != '0) & ~sel_ok);
    end
  end

  // Overflow: push into a full FIFO that is not popped in the same cycle.
  always_comb begin
    f_over = io.out_en & f_full & ~(io.out_ready & f_valid);
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    io_fifo #(.DW(DW), .DEPTH(OUT_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_geral (rst_geral),
      .push      (io.out_en[j]),
      .din       (io.proc_out),
      .pop       (io.out_ready[j]),
      .dout      (f_dout[j]),
      .valid     (f_valid[j]),
      .full      (f_full[j])
    );
  end

  // Pack FIFO heads onto the output bus.
  always_comb begin
    io.out_data = '0;
    for (int j = 0; j < N_OUT; j++) io.out_data[j*DW +: DW] = f_dout[j];
  end

  assign io.in_ready  = in_rdy;
  assign io.proc_in   = rd_mux;
  assign io.out_valid = f_valid;
  assign io.itr       = itr_r;
  assign io.err_flags = err_r;
endmodule

// File: tb/tb_sapho_io_hub.sv
// Self-checking bench for sapho_io_hub: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_sapho_io_hub;
  localparam int DW = 32, N_IN = 2, N_OUT = 5, DEPTH = 4;

  logic clk = 1'b0;
  logic rst_geral;
  always #5 clk = ~clk;

  sapho_io_hub_if #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  sapho_io_hub #(.DW(DW), .N_IN(N_IN), .N_OUT(N_OUT), .OUT_DEPTH(DEPTH),
                 .ITR_MASK(2'b11)) dut (
    .clk       (clk),
    .rst_geral (rst_geral),
    .io        (bus)
  );

  // Reference model state
  logic [DW-1:0] m_hold [N_IN];
  bit            m_hv   [N_IN];
  logic [DW-1:0] m_q    [N_OUT][$];
  logic [DW-1:0] m_last [N_OUT];
  bit            m_itr;
  logic [2:0]    m_err;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.req_in    = '0;
    bus.proc_out  = '0;
    bus.out_en    = '0;
    bus.out_ready = '0;
  endtask

  // Compare DUT against the model for the current inputs, advance the model,
  // then move to the next falling edge.
  task automatic tick();
    int            nreq;
    bit            one;
    bit            cap_any;
    logic [DW-1:0] pe;
    logic [N_IN-1:0] rdy_e;
    #1;
    nreq = $countones(bus.req_in);
    one  = (nreq == 1);
    pe   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (one && bus.req_in[k]) pe = m_hold[k];
      rdy_e[k] = !m_hv[k] || (one && bus.req_in[k]);
    end
    check("proc_in", bus.proc_in, pe);
    check("in_ready", DW'(bus.in_ready), DW'(rdy_e));
    for (int j = 0; j < N_OUT; j++) begin
      check($sformatf("out_valid[%0d]", j), DW'(bus.out_valid[j]), DW'(m_q[j].size() != 0));
      check($sformatf("out_data[%0d]", j), bus.out_data[j*DW +: DW],
            (m_q[j].size() != 0) ? m_q[j][0] : m_last[j]);
    end
    check("itr", DW'(bus.itr), DW'(m_itr));
    check("err_flags", DW'(bus.err_flags), DW'(m_err));

    if (rst_geral) begin
      for (int k = 0; k < N_IN; k++) begin
        m_hold[k] = '0;
        m_hv[k]   = 1'b0;
      end
      for (int j = 0; j < N_OUT; j++) begin
        m_q[j].delete();
        m_last[j] = '0;
      end
      m_itr = 1'b0;
      m_err = 3'b000;
    end else begin
      if (nreq > 1) m_err[2] = 1'b1;
      for (int k = 0; k < N_IN; k++) begin
        if (one && bus.req_in[k]) begin
          if (m_hv[k]) m_hv[k] = 1'b0;
          else         m_err[0] = 1'b1;
        end
      end
      cap_any = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
        if (bus.in_valid[k] && rdy_e[k]) begin
          m_hold[k] = bus.in_data[k*DW +: DW];
          m_hv[k]   = 1'b1;
          cap_any   = 1'b1;
        end
      end
      m_itr = cap_any;
      for (int j = 0; j < N_OUT; j++) begin
        if (bus.out_ready[j] && (m_q[j].size() != 0)) m_last[j] = m_q[j].pop_front();
        if (bus.out_en[j]) begin
          if (m_q[j].size() < DEPTH) m_q[j].push_back(bus.proc_out);
          else                       m_err[1] = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_geral = 1'b1;
    tick();
    rst_geral = 1'b0;
  endtask

  task automatic write_out(input logic [N_OUT-1:0] en, input logic [DW-1:0] v);
    idle();
    bus.out_en   = en;
    bus.proc_out = v;
    tick();
  endtask

  initial begin
    idle();
    rst_geral = 1'b1;
    @(negedge clk);
    tick();
    rst_geral = 1'b0;

    // 1. Reset mid-traffic with FIFOs 1 and 3 half full
    write_out(5'b00010, 32'd11);
    write_out(5'b00010, 32'd12);
    write_out(5'b01000, 32'd13);
    write_out(5'b01000, 32'd14);
    idle();
    bus.in_valid = 2'b01;
    bus.in_data[0 +: DW] = 32'd99;
    bus.out_en = 5'b01010;
    rst_geral = 1'b1;
    tick();
    rst_geral = 1'b0;
    idle();
    #1;
    check("rst out_valid", DW'(bus.out_valid), 32'd0);
    check("rst in_ready", DW'(bus.in_ready), 32'd3);
    check("rst err_flags", DW'(bus.err_flags), 32'd0);
    check("rst itr", DW'(bus.itr), 32'd0);
    tick();

    // 2. Input path with a negative sample and interrupt
    bus.in_valid = 2'b10;
    bus.in_data[DW +: DW] = 32'hFFFF_FFF6;
    tick();
    idle();
    bus.req_in = 2'b10;
    #1;
    check("neg proc_in", bus.proc_in, 32'hFFFF_FFF6);
    check("itr pulse", DW'(bus.itr), 32'd1);
    tick();
    idle();
    #1;
    check("itr single", DW'(bus.itr), 32'd0);
    check("hv1 cleared", DW'(bus.in_ready), 32'd3);
    tick();

    // 3. Pop and capture on channel 0 in the same cycle
    bus.in_valid = 2'b01;
    bus.in_data[0 +: DW] = 32'd5;
    tick();
    idle();
    bus.req_in = 2'b01;
    bus.in_valid = 2'b01;
    bus.in_data[0 +: DW] = 32'd7;
    #1;
    check("popcap proc_in", bus.proc_in, 32'd5);
    check("popcap in_ready0", DW'(bus.in_ready[0]), 32'd1);
    tick();
    idle();
    bus.req_in = 2'b01;
    #1;
    check("popcap reread", bus.proc_in, 32'd7);
    tick();

    // 4. Fill FIFO 2 past its depth, then drain
    for (int i = 1; i <= 5; i++) write_out(5'b00100, DW'(i));
    idle();
    #1;
    check("overflow set", DW'(bus.err_flags[1]), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle();
      bus.out_ready = 5'b00100;
      #1;
      check("drain order", bus.out_data[2*DW +: DW], DW'(i));
      tick();
    end
    idle();
    #1;
    check("drained empty", DW'(bus.out_valid[2]), 32'd0);
    tick();

    // 5. Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 1; i <= 4; i++) write_out(5'b00100, DW'(i));
    idle();
    bus.out_en = 5'b00100;
    bus.proc_out = 32'd9;
    bus.out_ready = 5'b00100;
    tick();
    idle();
    #1;
    check("full pushpop no ovf", DW'(bus.err_flags[1]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.out_ready = 5'b00100;
      #1;
      check("full pushpop order", bus.out_data[2*DW +: DW], (i == 3) ? 32'd9 : DW'(i + 2));
      tick();
    end

    // 6. Error cases
    idle();
    bus.in_valid = 2'b11;
    bus.in_data = {32'd8, 32'd7};
    tick();
    idle();
    bus.req_in = 2'b11;
    #1;
    check("multi-sel proc_in", bus.proc_in, 32'd0);
    tick();
    idle();
    #1;
    check("sel_err", DW'(bus.err_flags[2]), 32'd1);
    check("no pop on multi-sel", DW'(bus.in_ready), 32'd0);
    bus.req_in = 2'b01;
    tick();
    idle();
    bus.req_in = 2'b01;
    #1;
    check("empty read proc_in", bus.proc_in, 32'd7);
    tick();
    idle();
    #1;
    check("underflow", DW'(bus.err_flags[0]), 32'd1);
    write_out(5'b10001, 32'd3);
    idle();
    #1;
    check("bcast fifo0", bus.out_data[0 +: DW], 32'd3);
    check("bcast fifo4", bus.out_data[4*DW +: DW], 32'd3);
    tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst_geral     = ($urandom_range(0, 79) == 0);
      bus.in_data   = {$urandom(), $urandom()};
      bus.in_valid  = N_IN'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       bus.req_in = 2'b00;
        3:       bus.req_in = 2'b11;
        default: bus.req_in = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      endcase
      bus.proc_out  = $urandom();
      bus.out_en    = N_OUT'($urandom_range(0, 31) & $urandom_range(0, 31));
      bus.out_ready = N_OUT'($urandom_range(0, 31));
      tick();
    end
    rst_geral = 1'b0;
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
